// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Purpose:
//   Sequences conditional-branch resolution in the ID stage of a 5-stage
//   pipeline. Passes the decoded condition code to the branch comparator,
//   stalls PC and IF/ID while forwarded branch operands are pending, samples
//   the comparator once the operands are valid, and issues a registered
//   one-cycle PC redirect with IF/ID (and optionally ID/EX) flush control.
//
// Parameters:
//   DELAY_SLOT : 1 = delay-slot semantics (ID instruction survives redirect),
//                0 = no delay slot (ID instruction is also squashed)
//   WAIT_MAX   : operand-wait cycles before the sticky timeout flag sets
//
// Optional feature (macro BRANCH_STATS_EN):
//   Defined   : stat_branches / stat_taken / stat_stall_cycles count resolves,
//               taken resolves and stall_id cycles (wrapping, frozen while
//               pipe_stall, cleared by rst only).
//   Undefined : the stat ports exist and are tied to zero.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   id_valid, id_is_branch   ID holds a valid conditional branch
//   id_br_op, id_br_unsigned comparator condition code / unsigned select
//   id_br_negate             invert comparator result (bne-style branches)
//   id_target                branch target address
//   need_rs, need_rt         branch reads rs / rt
//   rs_ready, rt_ready       forwarded rs / rt value valid this cycle
//   cmp_result               comparator output (same cycle)
//   pipe_stall, pipe_flush   downstream freeze / exception flush
//   cmp_op, cmp_unsigned     comparator controls (passthrough)
//   stall_id                 hold PC and IF/ID
//   redirect_valid/_pc       PC redirect request and latched target
//   flush_if, flush_id       squash IF/ID and ID/EX register inputs
//   wait_timeout             sticky operand-wait timeout
//   stat_*                   optional statistics counters
// -----------------------------------------------------------------------------
module branch_resolve_ctrl #(
    parameter int DELAY_SLOT = 1,
    parameter int WAIT_MAX   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_is_branch,
    input  logic [3:0]  id_br_op,
    input  logic        id_br_unsigned,
    input  logic        id_br_negate,
    input  logic [31:0] id_target,
    input  logic        need_rs,
    input  logic        need_rt,
    input  logic        rs_ready,
    input  logic        rt_ready,
    input  logic        cmp_result,
    input  logic        pipe_stall,
    input  logic        pipe_flush,
    output logic [3:0]  cmp_op,
    output logic        cmp_unsigned,
    output logic        stall_id,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic        wait_timeout,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_stall_cycles
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_MAX_C = CW'(WAIT_MAX);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic          FLUSH_ID_ON_REDIR = (DELAY_SLOT == 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t         state_r;
    logic           redirect_valid_r;
    logic [31:0]    redirect_pc_r;
    logic           flush_if_r;
    logic           flush_id_r;
    logic [CW-1:0]  wait_cnt_r;
    logic           wait_timeout_r;

    logic           br_req_s;
    logic           opnd_ok_s;
    logic           taken_s;
    logic           stall_id_s;
    logic [CW-1:0]  cnt_inc_s;

    assign br_req_s  = id_valid & id_is_branch;
    assign opnd_ok_s = (~need_rs | rs_ready) & (~need_rt | rt_ready);
    assign taken_s   = cmp_result ^ id_br_negate;

    // Saturating increment of the operand-wait counter.
    assign cnt_inc_s = (wait_cnt_r == WAIT_MAX_C) ? wait_cnt_r : (wait_cnt_r + CNT_ONE);

    assign cmp_op       = id_br_op;
    assign cmp_unsigned = id_br_unsigned;

    // Stall request: combinational so the PC/IF-ID hold takes effect in the
    // same cycle the missing operand is detected; a flush overrides it.
    always_comb begin
        stall_id_s = 1'b0;
        if (pipe_flush) begin
            stall_id_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:  stall_id_s = br_req_s & ~opnd_ok_s;
                ST_WAIT:  stall_id_s = ~opnd_ok_s;
                ST_REDIR: stall_id_s = br_req_s;   // hold a back-to-back branch one cycle
                default:  stall_id_s = 1'b0;
            endcase
        end
    end

    assign stall_id       = stall_id_s;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    // The flush strobes are suppressed in a pipe_flush cycle; the exception
    // path owns the squash then.
    assign flush_if       = flush_if_r & ~pipe_flush;
    assign flush_id       = flush_id_r & ~pipe_flush;
    assign wait_timeout   = wait_timeout_r;

    // Resolution FSM with registered redirect/flush outputs and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
            flush_if_r       <= 1'b0;
            flush_id_r       <= 1'b0;
            wait_cnt_r       <= CNT_ZERO;
            wait_timeout_r   <= 1'b0;
        end else if (pipe_flush) begin
            state_r          <= ST_IDLE;
            redirect_valid_r <= 1'b0;
            flush_if_r       <= 1'b0;
            flush_id_r       <= 1'b0;
            wait_cnt_r       <= CNT_ZERO;
        end else if (pipe_stall) begin
            // Frozen: state, counter and a pending redirect all hold.
            state_r <= state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (br_req_s && opnd_ok_s) begin
                        if (taken_s) begin
                            state_r          <= ST_REDIR;
                            redirect_valid_r <= 1'b1;
                            redirect_pc_r    <= id_target;
                            flush_if_r       <= 1'b1;
                            flush_id_r       <= FLUSH_ID_ON_REDIR;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else if (br_req_s) begin
                        state_r        <= ST_WAIT;
                        wait_cnt_r     <= CNT_ONE;
                        wait_timeout_r <= wait_timeout_r | (CNT_ONE == WAIT_MAX_C);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!br_req_s) begin
                        // Branch squashed upstream while waiting.
                        state_r    <= ST_IDLE;
                        wait_cnt_r <= CNT_ZERO;
                    end else if (opnd_ok_s) begin
                        wait_cnt_r <= CNT_ZERO;
                        if (taken_s) begin
                            state_r          <= ST_REDIR;
                            redirect_valid_r <= 1'b1;
                            redirect_pc_r    <= id_target;
                            flush_if_r       <= 1'b1;
                            flush_id_r       <= FLUSH_ID_ON_REDIR;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        wait_cnt_r     <= cnt_inc_s;
                        wait_timeout_r <= wait_timeout_r | (cnt_inc_s == WAIT_MAX_C);
                    end
                end
                ST_REDIR: begin
                    // One-cycle redirect pulse.
                    state_r          <= ST_IDLE;
                    redirect_valid_r <= 1'b0;
                    flush_if_r       <= 1'b0;
                    flush_id_r       <= 1'b0;
                end
                default: begin
                    state_r          <= ST_IDLE;
                    redirect_valid_r <= 1'b0;
                    flush_if_r       <= 1'b0;
                    flush_id_r       <= 1'b0;
                    wait_cnt_r       <= CNT_ZERO;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic        resolve_s;
    logic [31:0] stat_branches_r;
    logic [31:0] stat_taken_r;
    logic [31:0] stat_stall_r;

    // A resolve happens when a branch with valid operands is evaluated in
    // IDLE or WAIT and the pipe is neither flushed nor frozen.
    assign resolve_s = ~pipe_flush & ~pipe_stall & br_req_s & opnd_ok_s &
                       ((state_r == ST_IDLE) | (state_r == ST_WAIT));

    // Statistics counters, wrapping, frozen while the pipe is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_r <= 32'd0;
            stat_taken_r    <= 32'd0;
            stat_stall_r    <= 32'd0;
        end else if (pipe_stall) begin
            stat_branches_r <= stat_branches_r;
        end else begin
            if (resolve_s) begin
                stat_branches_r <= stat_branches_r + 32'd1;
            end else begin
                stat_branches_r <= stat_branches_r;
            end
            if (resolve_s && taken_s) begin
                stat_taken_r <= stat_taken_r + 32'd1;
            end else begin
                stat_taken_r <= stat_taken_r;
            end
            if (stall_id_s) begin
                stat_stall_r <= stat_stall_r + 32'd1;
            end else begin
                stat_stall_r <= stat_stall_r;
            end
        end
    end

    assign stat_branches     = stat_branches_r;
    assign stat_taken        = stat_taken_r;
    assign stat_stall_cycles = stat_stall_r;
`else
    assign stat_branches     = 32'd0;
    assign stat_taken        = 32'd0;
    assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for branch_resolve_ctrl. Two instances share the
// inputs: one with a delay slot (DELAY_SLOT=1), one without (DELAY_SLOT=0).
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_is_branch;
    logic [3:0]  id_br_op;
    logic        id_br_unsigned, id_br_negate;
    logic [31:0] id_target;
    logic        need_rs, need_rt, rs_ready, rt_ready;
    logic        cmp_result, pipe_stall, pipe_flush;

    logic [3:0]  cmp_op_1, cmp_op_0;
    logic        cmp_uns_1, cmp_uns_0;
    logic        stall_1, stall_0;
    logic        rv_1, rv_0;
    logic [31:0] pc_1, pc_0;
    logic        fif_1, fif_0, fid_1, fid_0;
    logic        tmo_1, tmo_0;
    logic [31:0] sb_1, st_1, ss_1, sb_0, st_0, ss_0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.DELAY_SLOT(1), .WAIT_MAX(15)) u_ds1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_br_op(id_br_op), .id_br_unsigned(id_br_unsigned), .id_br_negate(id_br_negate),
        .id_target(id_target), .need_rs(need_rs), .need_rt(need_rt),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .cmp_result(cmp_result),
        .pipe_stall(pipe_stall), .pipe_flush(pipe_flush),
        .cmp_op(cmp_op_1), .cmp_unsigned(cmp_uns_1), .stall_id(stall_1),
        .redirect_valid(rv_1), .redirect_pc(pc_1), .flush_if(fif_1), .flush_id(fid_1),
        .wait_timeout(tmo_1), .stat_branches(sb_1), .stat_taken(st_1),
        .stat_stall_cycles(ss_1)
    );

    branch_resolve_ctrl #(.DELAY_SLOT(0), .WAIT_MAX(15)) u_ds0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_br_op(id_br_op), .id_br_unsigned(id_br_unsigned), .id_br_negate(id_br_negate),
        .id_target(id_target), .need_rs(need_rs), .need_rt(need_rt),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .cmp_result(cmp_result),
        .pipe_stall(pipe_stall), .pipe_flush(pipe_flush),
        .cmp_op(cmp_op_0), .cmp_unsigned(cmp_uns_0), .stall_id(stall_0),
        .redirect_valid(rv_0), .redirect_pc(pc_0), .flush_if(fif_0), .flush_id(fid_0),
        .wait_timeout(tmo_0), .stat_branches(sb_0), .stat_taken(st_0),
        .stat_stall_cycles(ss_0)
    );

    // Single comparison point: counts and reports.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_branch(input logic [31:0] tgt, input logic nrs, input logic nrt,
                              input logic rsr, input logic rtr, input logic cmp,
                              input logic neg);
        id_valid     = 1'b1;
        id_is_branch = 1'b1;
        id_target    = tgt;
        need_rs      = nrs;
        need_rt      = nrt;
        rs_ready     = rsr;
        rt_ready     = rtr;
        cmp_result   = cmp;
        id_br_negate = neg;
    endtask

    task automatic no_branch();
        id_valid     = 1'b0;
        id_is_branch = 1'b0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_is_branch = 1'b0;
        id_br_op = 4'hA; id_br_unsigned = 1'b1; id_br_negate = 1'b0;
        id_target = 32'd0;
        need_rs = 1'b0; need_rt = 1'b0; rs_ready = 1'b0; rt_ready = 1'b0;
        cmp_result = 1'b0; pipe_stall = 1'b0; pipe_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check_eq("rst_rv", {31'd0, rv_1}, 32'd0);
        check_eq("rst_pc", pc_1, 32'd0);
        check_eq("rst_fif", {31'd0, fif_1}, 32'd0);
        check_eq("rst_tmo", {31'd0, tmo_1}, 32'd0);
        check_eq("rst_stats", sb_1 | st_1 | ss_1, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("cmp_op", {28'd0, cmp_op_1}, 32'h0000000A);
        check_eq("cmp_uns", {31'd0, cmp_uns_1}, 32'd1);
        check_eq("cmp_op_ds0", {27'd0, cmp_uns_0, cmp_op_0}, 32'h0000001A);
        tick();

        // T1: operands ready, taken -> one-cycle redirect
        set_branch(32'h00400040, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check_eq("t1_stall", {31'd0, stall_1}, 32'd0);
        check_eq("t1_rv_pre", {31'd0, rv_1}, 32'd0);
        tick();
        no_branch();
        #1;
        check_eq("t1_rv", {31'd0, rv_1}, 32'd1);
        check_eq("t1_pc", pc_1, 32'h00400040);
        check_eq("t1_fif", {31'd0, fif_1}, 32'd1);
        check_eq("t1_fid_ds1", {31'd0, fid_1}, 32'd0);
        check_eq("t1_rv_ds0", {31'd0, rv_0}, 32'd1);
        check_eq("t1_pc_ds0", pc_0, 32'h00400040);
        check_eq("t1_fif_ds0", {31'd0, fif_0}, 32'd1);
        check_eq("t1_fid_ds0", {31'd0, fid_0}, 32'd1);
        tick();
        check_eq("t1_rv_end", {31'd0, rv_1}, 32'd0);
        check_eq("t1_fif_end", {31'd0, fif_1}, 32'd0);
        check_eq("t1_pc_keep", pc_1, 32'h00400040);

        // T2: rs late for 3 cycles, cmp=0 negate=1 -> taken after stall
        set_branch(32'h00001000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t2_stall", {31'd0, stall_1}, 32'd1);
            check_eq("t2_rv_pre", {31'd0, rv_1}, 32'd0);
            tick();
        end
        rs_ready = 1'b1;
        #1;
        check_eq("t2_stall_rel", {31'd0, stall_1}, 32'd0);
        tick();
        no_branch();
        #1;
        check_eq("t2_rv", {31'd0, rv_1}, 32'd1);
        check_eq("t2_pc", pc_1, 32'h00001000);
        tick();
`ifdef BRANCH_STATS_EN
        check_eq("t2_stat_stall", ss_1, 32'd3);
        check_eq("t2_stat_taken", st_1, 32'd2);
        check_eq("t2_stat_br", sb_1, 32'd2);
`endif

        // T3: not-taken -> no redirect, no flush, no stall
        set_branch(32'h00002000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check_eq("t3_stall", {31'd0, stall_1}, 32'd0);
        check_eq("t3_stall_ds0", {31'd0, stall_0}, 32'd0);
        tick();
        no_branch();
        #1;
        check_eq("t3_rv", {31'd0, rv_1}, 32'd0);
        check_eq("t3_fif", {31'd0, fif_1}, 32'd0);
        check_eq("t3_ds0_flush", {30'd0, fif_0, fid_0}, 32'd0);
        check_eq("t3_pc_keep", pc_1, 32'h00001000);
        tick();

        // T4: rt never ready -> timeout after 15 stalled cycles, sticky
        set_branch(32'h00003000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        tick();
        for (int i = 0; i < 13; i++) tick();
        check_eq("t4_tmo_14", {31'd0, tmo_1}, 32'd0);
        check_eq("t4_stall", {31'd0, stall_1}, 32'd1);
        tick();
        check_eq("t4_tmo_15", {31'd0, tmo_1}, 32'd1);
        check_eq("t4_tmo_ds0", {31'd0, tmo_0}, 32'd1);
        tick();
        tick();
        rt_ready = 1'b1;
        #1;
        check_eq("t4_stall_rel", {31'd0, stall_1}, 32'd0);
        tick();
        no_branch();
        #1;
        check_eq("t4_tmo_sticky", {31'd0, tmo_1}, 32'd1);
        check_eq("t4_rv", {31'd0, rv_1}, 32'd0);
        tick();

        // T5A: redirect held by 2 stall cycles -> 3 cycles of redirect_valid
        set_branch(32'h00400080, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        no_branch();
        pipe_stall = 1'b1;
        #1;
        check_eq("t5a_rv_c1", {31'd0, rv_1}, 32'd1);
        tick();
        check_eq("t5a_rv_c2", {31'd0, rv_1}, 32'd1);
        check_eq("t5a_pc", pc_1, 32'h00400080);
        tick();
        pipe_stall = 1'b0;
        #1;
        check_eq("t5a_rv_c3", {31'd0, rv_1}, 32'd1);
        check_eq("t5a_fif_c3", {31'd0, fif_1}, 32'd1);
        tick();
        check_eq("t5a_rv_end", {31'd0, rv_1}, 32'd0);

        // T5B: stalled redirect then pipe_flush -> cleared on next edge
        set_branch(32'h00400100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        no_branch();
        pipe_stall = 1'b1;
        #1;
        check_eq("t5b_rv_c1", {31'd0, rv_1}, 32'd1);
        tick();
        pipe_flush = 1'b1;
        #1;
        check_eq("t5b_rv_flushcyc", {31'd0, rv_1}, 32'd1);
        check_eq("t5b_fif_flushcyc", {31'd0, fif_1}, 32'd0);
        check_eq("t5b_fid_ds0_flushcyc", {31'd0, fid_0}, 32'd0);
        check_eq("t5b_stall_flushcyc", {31'd0, stall_1}, 32'd0);
        check_eq("t5b_pc", pc_1, 32'h00400100);
        tick();
        pipe_flush = 1'b0;
        pipe_stall = 1'b0;
        #1;
        check_eq("t5b_rv_after", {31'd0, rv_1}, 32'd0);
        check_eq("t5b_fif_after", {31'd0, fif_1}, 32'd0);
        tick();

        // T6: back-to-back branch held one cycle during redirect
        set_branch(32'h00000200, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        set_branch(32'h00000300, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check_eq("t6_stall_redir", {31'd0, stall_1}, 32'd1);
        check_eq("t6_rv", {31'd0, rv_1}, 32'd1);
        tick();
        check_eq("t6_stall_idle", {31'd0, stall_1}, 32'd0);
        check_eq("t6_rv_idle", {31'd0, rv_1}, 32'd0);
        tick();
        no_branch();
        #1;
        check_eq("t6_rv_nt", {31'd0, rv_1}, 32'd0);
        check_eq("t6_pc_keep", pc_1, 32'h00000200);

        // T7: branch squashed upstream while waiting -> back to IDLE
        set_branch(32'h00000400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        tick();
        no_branch();
        #1;
        check_eq("t7_stall_wait", {31'd0, stall_1}, 32'd1);
        tick();
        check_eq("t7_stall_idle", {31'd0, stall_1}, 32'd0);
        rs_ready = 1'b1;
        tick();

`ifdef BRANCH_STATS_EN
        check_eq("stat_br", sb_1, 32'd8);
        check_eq("stat_taken", st_1, 32'd5);
        check_eq("stat_stall", ss_1, 32'd23);
        check_eq("stat_br_ds0", sb_0, 32'd8);
        check_eq("stat_taken_ds0", st_0, 32'd5);
        check_eq("stat_stall_ds0", ss_0, 32'd23);
`else
        check_eq("stat_tied_ds1", sb_1 | st_1 | ss_1, 32'd0);
        check_eq("stat_tied_ds0", sb_0 | st_0 | ss_0, 32'd0);
`endif

        // T8: asynchronous reset in the middle of a redirect
        set_branch(32'h00000500, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        #1;
        check_eq("t8_rv_pre", {31'd0, rv_1}, 32'd1);
        check_eq("t8_stall_pre", {31'd0, stall_1}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t8_rv_rst", {31'd0, rv_1}, 32'd0);
        check_eq("t8_stall_rst", {31'd0, stall_1}, 32'd0);
        check_eq("t8_fif_rst", {31'd0, fif_1}, 32'd0);
        check_eq("t8_pc_rst", pc_1, 32'd0);
        check_eq("t8_stats_rst", sb_1 | st_1 | ss_1, 32'd0);
        no_branch();
        #1;
        rst = 1'b0;
        tick();
        check_eq("t8_rv_idle", {31'd0, rv_1}, 32'd0);
        check_eq("t8_tmo_cleared", {31'd0, tmo_1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
